// File: rtl/load_store_sequencer_pkg.sv
// Shared micro-code definitions for the load/store unit.
//   LoadStoreUnitFuncts / LoadStoreUnitBytes : ld_st_unit fields of the decoded micro-code
//   S_*                                      : load_store_sequencer FSM state encodings
//   LANE_BE_*                                : byte-enable masks for lane 0, shifted by address
package load_store_sequencer_pkg;

    typedef enum logic [2:0] {
        LD            = 3'd0,
        LDU           = 3'd1,
        ST            = 3'd2,
        FENCE         = 3'd3,
        FENCEI        = 3'd4,
        FUNCT_UNKNOWN = 3'd7
    } LoadStoreUnitFuncts;

    typedef enum logic [1:0] {
        BYTE          = 2'd0,
        HALF          = 2'd1,
        WORD          = 2'd2,
        BYTES_UNKNOWN = 2'd3
    } LoadStoreUnitBytes;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RETIRE = 2'd3;

    localparam logic [3:0] LANE_BE_BYTE = 4'b0001;
    localparam logic [3:0] LANE_BE_HALF = 4'b0011;
    localparam logic [3:0] LANE_BE_WORD = 4'b1111;

    // True for the functions that touch the data-memory bus.
    function automatic logic is_mem_op(input LoadStoreUnitFuncts f);
        return (f == LD) || (f == LDU) || (f == ST);
    endfunction

endpackage

// File: rtl/load_store_sequencer_ls_lane_align.sv
// Combinational byte-lane steering shared by the store and load paths.
//   bytes    : access size
//   addr_lo  : address bits [1:0]
//   sign_ext : 1 = sign-extend narrow loads (LD), 0 = zero-extend (LDU)
//   st_data  : raw store data (rs2)
//   ld_raw   : raw 32-bit word returned by memory
//   be       : byte enables for the access (0 for an unknown size)
//   st_lanes : store data replicated across all lanes of its size
//   ld_data  : selected and extended load result
module ls_lane_align
    import load_store_sequencer_pkg::*;
(
    input  LoadStoreUnitBytes bytes,
    input  logic [1:0]        addr_lo,
    input  logic              sign_ext,
    input  logic [31:0]       st_data,
    input  logic [31:0]       ld_raw,
    output logic [3:0]        be,
    output logic [31:0]       st_lanes,
    output logic [31:0]       ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        case (addr_lo)
            2'd0:    ld_byte = ld_raw[7:0];
            2'd1:    ld_byte = ld_raw[15:8];
            2'd2:    ld_byte = ld_raw[23:16];
            default: ld_byte = ld_raw[31:24];
        endcase
        ld_half = addr_lo[1] ? ld_raw[31:16] : ld_raw[15:0];
    end

    always_comb begin
        be       = 4'b0000;
        st_lanes = st_data;
        ld_data  = ld_raw;
        case (bytes)
            BYTE: begin
                be       = LANE_BE_BYTE << addr_lo;
                st_lanes = {4{st_data[7:0]}};
                ld_data  = {{24{sign_ext & ld_byte[7]}}, ld_byte};
            end
            HALF: begin
                be       = LANE_BE_HALF << {addr_lo[1], 1'b0};
                st_lanes = {2{st_data[15:0]}};
                ld_data  = {{16{sign_ext & ld_half[15]}}, ld_half};
            end
            WORD: begin
                be = LANE_BE_WORD;
            end
            default: begin
                be = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/load_store_sequencer.sv
// Multi-cycle load/store controller: runs one request/grant/response transaction
// on the data-memory bus per instruction and stalls the core until it retires.
//   clk, rst                        : clock, asynchronous active-high reset
//   req_en/funct/bytes/addr/wdata   : ld_st_unit micro-code fields, ALU address, rs2
//   stall                           : hold PC / register write of the current instruction
//   done                            : one-cycle retire pulse; ld_data and exc_* valid with it
//   exc_misaligned/illegal/bus_err  : at most one set, priority illegal > misaligned > bus_err
//   fence_i_flush                   : FENCE.I retiring
//   mem_req/we/addr/be/wdata        : bus request, driven only while issuing
//   mem_gnt/rvalid/rdata/err        : bus grant and response
module load_store_sequencer
    import load_store_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_en,
    input  LoadStoreUnitFuncts req_funct,
    input  LoadStoreUnitBytes  req_bytes,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               stall,
    output logic               done,
    output logic [31:0]        ld_data,
    output logic               exc_misaligned,
    output logic               exc_illegal,
    output logic               exc_bus_err,
    output logic               fence_i_flush,
    output logic               mem_req,
    output logic               mem_we,
    output logic [31:0]        mem_addr,
    output logic [3:0]         mem_be,
    output logic [31:0]        mem_wdata,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [31:0]        mem_rdata,
    input  logic               mem_err
);

    logic [1:0]         state, state_nxt;
    LoadStoreUnitFuncts funct_q;
    LoadStoreUnitBytes  bytes_q;
    logic [31:0]        addr_q, wdata_q, rdata_q;
    logic               ill_q, mis_q, bus_err_q;
    logic [15:0]        wait_cnt;

    logic               req_ill, req_mis, timeout_hit;
    logic               issuing, is_load, any_exc;
    logic [3:0]         lane_be;
    logic [31:0]        lane_wdata, lane_ld;

    // Classify the incoming request; misalignment only matters for legal bus accesses.
    always_comb begin
        req_ill = 1'b0;
        req_mis = 1'b0;
        case (req_funct)
            LD, LDU, ST: begin
                req_ill = (req_bytes == BYTES_UNKNOWN);
                req_mis = ((req_bytes == HALF) && req_addr[0]) ||
                          ((req_bytes == WORD) && (req_addr[1:0] != 2'b00));
            end
            FENCE, FENCEI: begin
                req_ill = 1'b0;
            end
            default: begin
                req_ill = 1'b1;
            end
        endcase
    end

    // wait_cnt is 0 in the first WAIT cycle (one cycle after grant), so firing at
    // wait_cnt + 2 >= TIMEOUT retires exactly TIMEOUT cycles after the grant.
    assign timeout_hit = ({1'b0, wait_cnt} + 17'd2) >= 17'(TIMEOUT);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_en) begin
                    // Only one access is ever outstanding, so fences retire without draining.
                    if (req_ill || req_mis || !is_mem_op(req_funct))
                        state_nxt = S_RETIRE;
                    else
                        state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_gnt)
                    state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rvalid || timeout_hit)
                    state_nxt = S_RETIRE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            funct_q   <= LD;
            bytes_q   <= BYTE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            ill_q     <= 1'b0;
            mis_q     <= 1'b0;
            bus_err_q <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            state <= state_nxt;

            if ((state == S_IDLE) && req_en) begin
                funct_q   <= req_funct;
                bytes_q   <= req_bytes;
                addr_q    <= req_addr;
                wdata_q   <= req_wdata;
                ill_q     <= req_ill;
                mis_q     <= req_mis;
                bus_err_q <= 1'b0;
            end

            if ((state == S_ISSUE) && mem_gnt)
                wait_cnt <= '0;
            else if (state == S_WAIT)
                wait_cnt <= wait_cnt + 16'd1;

            // A response arriving together with the timeout still wins.
            if (state == S_WAIT) begin
                if (mem_rvalid) begin
                    rdata_q   <= mem_rdata;
                    bus_err_q <= mem_err;
                end else if (timeout_hit) begin
                    bus_err_q <= 1'b1;
                end
            end
        end
    end

    ls_lane_align u_lane_align (
        .bytes    (bytes_q),
        .addr_lo  (addr_q[1:0]),
        .sign_ext (funct_q == LD),
        .st_data  (wdata_q),
        .ld_raw   (rdata_q),
        .be       (lane_be),
        .st_lanes (lane_wdata),
        .ld_data  (lane_ld)
    );

    assign issuing = (state == S_ISSUE);
    assign is_load = (funct_q == LD) || (funct_q == LDU);
    assign any_exc = ill_q || mis_q || bus_err_q;

    assign done  = (state == S_RETIRE);
    // rst is folded in so stall is low while reset is held even with req_en up.
    assign stall = req_en && !done && !rst;

    // Bus outputs are zero outside ISSUE so nothing stale leaks onto the bus.
    assign mem_req   = issuing;
    assign mem_we    = issuing && (funct_q == ST);
    assign mem_addr  = issuing ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_be    = issuing ? lane_be : 4'b0000;
    assign mem_wdata = issuing ? lane_wdata : 32'd0;

    assign exc_illegal    = done && ill_q;
    assign exc_misaligned = done && !ill_q && mis_q;
    assign exc_bus_err    = done && !ill_q && !mis_q && bus_err_q;
    assign fence_i_flush  = done && !ill_q && (funct_q == FENCEI);
    assign ld_data        = (done && is_load && !any_exc) ? lane_ld : 32'd0;

endmodule

// File: tb/tb_load_store_sequencer.sv
// Directed bench for load_store_sequencer (TIMEOUT = 4). Inputs change 2 time
// units after each rising edge, outputs are sampled 1 unit later.
module tb_load_store_sequencer;
    import load_store_sequencer_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               req_en;
    LoadStoreUnitFuncts req_funct;
    LoadStoreUnitBytes  req_bytes;
    logic [31:0]        req_addr, req_wdata;
    logic               stall, done;
    logic [31:0]        ld_data;
    logic               exc_misaligned, exc_illegal, exc_bus_err, fence_i_flush;
    logic               mem_req, mem_we;
    logic [31:0]        mem_addr, mem_wdata;
    logic [3:0]         mem_be;
    logic               mem_gnt, mem_rvalid, mem_err;
    logic [31:0]        mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    load_store_sequencer #(.TIMEOUT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_en         (req_en),
        .req_funct      (req_funct),
        .req_bytes      (req_bytes),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .stall          (stall),
        .done           (done),
        .ld_data        (ld_data),
        .exc_misaligned (exc_misaligned),
        .exc_illegal    (exc_illegal),
        .exc_bus_err    (exc_bus_err),
        .fence_i_flush  (fence_i_flush),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_be         (mem_be),
        .mem_wdata      (mem_wdata),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .mem_err        (mem_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // {done, illegal, misaligned, bus_err, fence_i_flush}
    function automatic logic [31:0] flags();
        return {27'd0, done, exc_illegal, exc_misaligned, exc_bus_err, fence_i_flush};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".ctl"}, {24'd0, stall, done, exc_misaligned, exc_illegal,
                            exc_bus_err, fence_i_flush, mem_req, mem_we}, 32'd0);
        chk({tag, ".addr"}, mem_addr, 32'd0);
        chk({tag, ".be"}, {28'd0, mem_be}, 32'd0);
        chk({tag, ".wdata"}, mem_wdata, 32'd0);
        chk({tag, ".ld"}, ld_data, 32'd0);
    endtask

    task automatic present(input LoadStoreUnitFuncts f, input LoadStoreUnitBytes b,
                           input logic [31:0] addr, input logic [31:0] wd);
        req_en = 1'b1; req_funct = f; req_bytes = b; req_addr = addr; req_wdata = wd;
    endtask

    // Full bus access: IDLE, ISSUE (gnt after gnt_dly cycles), WAIT (response), RETIRE.
    task automatic mem_access(input string tag, input LoadStoreUnitFuncts f,
                              input LoadStoreUnitBytes b, input logic [31:0] addr,
                              input logic [31:0] wd, input int gnt_dly,
                              input logic [31:0] rd, input logic err,
                              input logic [3:0] exp_be, input logic [31:0] exp_wd,
                              input logic [31:0] exp_ld, input logic [4:0] exp_flags);
        present(f, b, addr, wd);
        #1;
        chk({tag, ".c1_stall"}, {31'd0, stall}, 32'd1);
        chk({tag, ".c1_req"}, {31'd0, mem_req}, 32'd0);
        next_cycle();
        for (int i = 0; i <= gnt_dly; i++) begin
            mem_gnt = (i == gnt_dly);
            #1;
            chk({tag, ".iss_req"}, {31'd0, mem_req}, 32'd1);
            chk({tag, ".iss_we"}, {31'd0, mem_we}, {31'd0, f == ST});
            chk({tag, ".iss_addr"}, mem_addr, {addr[31:2], 2'b00});
            chk({tag, ".iss_be"}, {28'd0, mem_be}, {28'd0, exp_be});
            chk({tag, ".iss_wdata"}, mem_wdata, exp_wd);
            chk({tag, ".iss_stall"}, {31'd0, stall}, 32'd1);
            next_cycle();
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rd; mem_err = err;
        #1;
        chk({tag, ".wait_req"}, {31'd0, mem_req}, 32'd0);
        chk({tag, ".wait_stall"}, {31'd0, stall}, 32'd1);
        chk({tag, ".wait_done"}, {31'd0, done}, 32'd0);
        next_cycle();
        mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = 32'h0;
        #1;
        chk({tag, ".ret_flags"}, flags(), {27'd0, exp_flags});
        chk({tag, ".ret_ld"}, ld_data, exp_ld);
        chk({tag, ".ret_stall"}, {31'd0, stall}, 32'd0);
        next_cycle();
        req_en = 1'b0;
        #1;
        chk({tag, ".after_done"}, {31'd0, done}, 32'd0);
    endtask

    // Accesses that retire in the cycle after IDLE without touching the bus.
    task automatic short_op(input string tag, input LoadStoreUnitFuncts f,
                            input LoadStoreUnitBytes b, input logic [31:0] addr,
                            input logic [4:0] exp_flags);
        present(f, b, addr, 32'hFFFF_FFFF);
        #1;
        chk({tag, ".c1_stall"}, {31'd0, stall}, 32'd1);
        chk({tag, ".c1_req"}, {31'd0, mem_req}, 32'd0);
        chk({tag, ".c1_done"}, {31'd0, done}, 32'd0);
        next_cycle();
        #1;
        chk({tag, ".c2_req"}, {31'd0, mem_req}, 32'd0);
        chk({tag, ".c2_flags"}, flags(), {27'd0, exp_flags});
        chk({tag, ".c2_ld"}, ld_data, 32'd0);
        chk({tag, ".c2_stall"}, {31'd0, stall}, 32'd0);
        next_cycle();
        req_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = 32'h0;
        present(LD, WORD, 32'hFFFF_FFFC, 32'hFFFF_FFFF);
        next_cycle();
        next_cycle();
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        req_en = 1'b0;
        next_cycle();

        // Bus accesses: be / replicated wdata / extended load result / flags
        mem_access("ld_byte3", LD, BYTE, 32'h0000_1003, 32'h0, 0, 32'h80FF_FF00, 1'b0,
                   4'b1000, 32'h0, 32'hFFFF_FF80, 5'b10000);
        mem_access("st_half2", ST, HALF, 32'h0000_2002, 32'h1234_ABCD, 3, 32'hFFFF_FFFF, 1'b0,
                   4'b1100, 32'hABCD_ABCD, 32'h0, 5'b10000);
        mem_access("ld_word_err", LD, WORD, 32'h0000_4000, 32'h0, 0, 32'hDEAD_BEEF, 1'b1,
                   4'b1111, 32'h0, 32'h0, 5'b10010);
        mem_access("ldu_half2", LDU, HALF, 32'h0000_6002, 32'h0, 0, 32'h8001_1234, 1'b0,
                   4'b1100, 32'h0, 32'h0000_8001, 5'b10000);
        mem_access("ld_half0", LD, HALF, 32'h0000_6000, 32'h0, 0, 32'h1234_8001, 1'b0,
                   4'b0011, 32'h0, 32'hFFFF_8001, 5'b10000);
        mem_access("st_byte1", ST, BYTE, 32'h0000_7001, 32'h0000_00A5, 1, 32'h0, 1'b0,
                   4'b0010, 32'hA5A5_A5A5, 32'h0, 5'b10000);
        mem_access("ld_word", LD, WORD, 32'h0000_8004, 32'h0, 0, 32'hCAFE_F00D, 1'b0,
                   4'b1111, 32'h0, 32'hCAFE_F00D, 5'b10000);
        mem_access("ldu_byte2", LDU, BYTE, 32'h0000_9002, 32'h0, 0, 32'h00AB_0000, 1'b0,
                   4'b0100, 32'h0, 32'h0000_00AB, 5'b10000);

        // Two-cycle retirements: exceptions and fences
        short_op("ldu_half_mis", LDU, HALF, 32'h0000_3001, 5'b10100);
        short_op("ld_word_mis", LD, WORD, 32'h0000_0102, 5'b10100);
        short_op("fencei", FENCEI, WORD, 32'h0, 5'b10001);
        short_op("fence", FENCE, BYTE, 32'h0, 5'b10000);
        short_op("unk_funct", FUNCT_UNKNOWN, WORD, 32'h0, 5'b11000);
        short_op("st_unk_bytes", ST, BYTES_UNKNOWN, 32'h0000_0003, 5'b11000);

        // Timeout: grant, then no response; retire 4 cycles after the grant
        present(LD, WORD, 32'h0000_5000, 32'h0);
        next_cycle();
        mem_gnt = 1'b1;
        #1;
        chk("to.gnt_req", {31'd0, mem_req}, 32'd1);
        next_cycle();
        mem_gnt = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            #1;
            chk("to.wait_done", {31'd0, done}, 32'd0);
            chk("to.wait_req", {31'd0, mem_req}, 32'd0);
            next_cycle();
        end
        #1;
        chk("to.flags", flags(), 32'b10010);
        chk("to.ld", ld_data, 32'd0);
        next_cycle();
        req_en = 1'b0;

        // Reset in WAIT, response arrives after reset release
        present(LD, WORD, 32'h0000_A000, 32'h0);
        next_cycle();
        mem_gnt = 1'b1;
        next_cycle();
        mem_gnt = 1'b0;
        #1;
        chk("rst.wait_stall", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        chk_all_zero("rst.async");
        next_cycle();
        chk_all_zero("rst.held");
        rst = 1'b0;
        req_en = 1'b0;
        next_cycle();
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        #1;
        chk("rst.late_rvalid_done", {31'd0, done}, 32'd0);
        next_cycle();
        mem_rvalid = 1'b0;
        #1;
        chk("rst.after_done", {31'd0, done}, 32'd0);
        chk("rst.after_ld", ld_data, 32'd0);
        next_cycle();
        short_op("rst.fence_idle", FENCE, WORD, 32'h0, 5'b10000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
